param_adder_seq: RTL and testbench



---
 rtl/param_adder_pkg.sv | 20 ++
 rtl/param_adder_seq_if.sv | 24 ++
 rtl/param_adder_seq_add_chunk.sv | 14 +
 rtl/param_adder_seq.sv | 124 ++++++++++++
 tb/tb_param_adder_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/param_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package param_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Counter needs one extra bit so it can step past the last chunk index without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
    return $clog2(width / chunk) + 1;
  endfunction

endpackage

// File: rtl/param_adder_seq_if.sv
// Operand/result valid-ready bundle for param_adder_seq.
interface param_adder_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/param_adder_seq_add_chunk.sv
// Combinational CHUNK-bit ripple slice with carry in/out.
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = (CHUNK+1)'(x) + (CHUNK+1)'(y) + (CHUNK+1)'(cin);

endmodule

// File: rtl/param_adder_seq.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock, with
// carry-out, signed overflow and valid/ready handshakes on both sides.
module param_adder_seq
  import param_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  param_adder_seq_if.slave  bus
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned CW     = cnt_width(WIDTH, CHUNK);
  localparam int unsigned MSB    = WIDTH - 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("param_adder_seq: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("param_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
  logic             cy_q, carry_q, ovf_q;
  logic             in_ready_q, out_valid_q;

  logic             accept_c, step_c, last_c;
  logic [31:0]      shift_c;
  logic [CHUNK-1:0] x_c, y_c, s_c;
  logic             cout_c;

  // Current slice of each latched operand, selected by the chunk counter.
  assign last_c  = (cnt_q == CW'(NCHUNK - 1));
  assign shift_c = 32'(cnt_q) * CHUNK;
  assign x_c     = CHUNK'(op_a_q >> shift_c);
  assign y_c     = CHUNK'(op_b_q >> shift_c);

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .x    (x_c),
    .y    (y_c),
    .cin  (cy_q),
    .s    (s_c),
    .cout (cout_c)
  );

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, chunk counter, running carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept_c) begin
      op_a_q <= bus.a;
      op_b_q <= bus.b;
      cnt_q  <= '0;
      cy_q   <= 1'b0;
    end else if (step_c) begin
      sum_q <= (sum_q & ~(CMASK << shift_c)) | (WIDTH'(s_c) << shift_c);
      cy_q  <= cout_c;
      cnt_q <= cnt_q + CW'(1);
      if (last_c) begin
        // The last slice holds the MSB, so s_c's top bit is the new sum MSB.
        carry_q <= cout_c;
        ovf_q   <= (op_a_q[MSB] == op_b_q[MSB]) && (s_c[CHUNK-1] != op_a_q[MSB]);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_param_adder_seq.sv
// Directed and randomized checks of param_adder_seq at 8/4 and 16/1.
module tb_param_adder_seq;

  localparam int NOPS = 1000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  param_adder_seq_if #(.WIDTH(8))  if8 ();
  param_adder_seq_if #(.WIDTH(16)) if16 ();

  param_adder_seq #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  param_adder_seq #(.WIDTH(16), .CHUNK(1)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 8-bit DUT with out_ready held high.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] esum,
                      input logic ec, input logic eo, input string tag);
    int lat;
    if8.a = a;
    if8.b = b;
    if8.in_valid  = 1'b1;
    if8.out_ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(if8.in_ready), 32'd1);
    step();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_out_valid"}, 32'(if8.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(if8.sum), 32'(esum));
    chk({tag, "_carry"}, 32'(if8.carry), 32'(ec));
    chk({tag, "_overflow"}, 32'(if8.overflow), 32'(eo));
    step();
    chk({tag, "_post_valid"}, 32'(if8.out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(if8.in_ready), 32'd1);
  endtask

  logic [15:0] ra, rb;
  logic        ro, iv, rdy, ov;
  logic [16:0] full;
  logic [17:0] e, got;
  logic [17:0] q[$];
  logic [7:0]  hs;
  logic        hc, ho;
  int          acc, res, cyc;
  string       rtag;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    if8.in_valid = 1'b0;  if8.out_ready = 1'b0;  if8.a = '0;  if8.b = '0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.a = '0; if16.b = '0;
    step();

    // Reset state
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_sum", 32'(if8.sum), 32'd0);
    chk("rst_carry", 32'(if8.carry), 32'd0);
    chk("rst_overflow", 32'(if8.overflow), 32'd0);
    rst = 1'b0;
    step();

    // Basic, carry and overflow vectors
    run8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, "t1");
    run8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "t2a");
    run8(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, "t2b");
    run8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "t3");
    run8(8'hC3, 8'h5A, 8'h1D, 1'b1, 1'b0, "t3b");

    // Backpressure: result must hold while a/b toggle and out_ready stays low
    if8.a = 8'h12; if8.b = 8'h34; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    step();
    if8.in_valid = 1'b0;
    step();
    step();
    chk("bp_valid", 32'(if8.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if8.a = 8'(i * 37); if8.b = 8'hFF - 8'(i); if8.in_valid = 1'(i % 2);
      step();
      chk("bp_hold_valid", 32'(if8.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(if8.in_ready), 32'd0);
      chk("bp_hold_flags", {22'd0, if8.carry, if8.overflow, if8.sum}, 32'h046);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(if8.out_valid), 32'd0);
    chk("bp_release_ready", 32'(if8.in_ready), 32'd1);
    step();
    chk("bp_single_handshake", 32'(if8.out_valid), 32'd0);

    // Asynchronous reset in the middle of RUN
    if8.a = 8'hFF; if8.b = 8'hFF; if8.in_valid = 1'b1;
    step();
    if8.in_valid = 1'b0;
    step();
    chk("mid_partial_sum", 32'(if8.sum[3:0]), 32'hE);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(if8.sum), 32'd0);
    chk("mid_rst_valid", 32'(if8.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(if8.in_ready), 32'd1);
    chk("mid_rst_flags", {30'd0, if8.carry, if8.overflow}, 32'd0);
    #2 rst = 1'b0;
    step();
    run8(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "t5");

    // Random back-to-back with in_valid held high and random out_ready
    for (int d = 0; d < 2; d++) begin
      acc = 0; res = 0; cyc = 0;
      q.delete();
      rtag = (d == 0) ? "rnd8" : "rnd16";
      while (res < NOPS && cyc < 40000) begin
        ra = 16'($urandom); rb = 16'($urandom); ro = 1'($urandom_range(0, 1));
        iv = (acc < NOPS);
        if8.a  = ra[7:0]; if8.b  = rb[7:0];
        if16.a = ra;      if16.b = rb;
        if8.in_valid  = (d == 0) && iv;
        if16.in_valid = (d == 1) && iv;
        if8.out_ready  = (d == 0) ? ro : 1'b1;
        if16.out_ready = (d == 1) ? ro : 1'b1;
        rdy = (d == 0) ? if8.in_ready  : if16.in_ready;
        ov  = (d == 0) ? if8.out_valid : if16.out_valid;
        if (iv && rdy) begin
          if (d == 0) begin
            full = 17'({1'b0, ra[7:0]} + {1'b0, rb[7:0]});
            hs = full[7:0]; hc = full[8];
            ho = (ra[7] == rb[7]) && (hs[7] != ra[7]);
            e = {ho, hc, 8'h00, hs};
          end else begin
            full = {1'b0, ra} + {1'b0, rb};
            ho = (ra[15] == rb[15]) && (full[15] != ra[15]);
            e = {ho, full[16], full[15:0]};
          end
          q.push_back(e);
          acc++;
        end
        if (ov && ro) begin
          got = (d == 0) ? {if8.overflow, if8.carry, 8'h00, if8.sum}
                         : {if16.overflow, if16.carry, if16.sum};
          if (q.size() == 0) begin
            chk({rtag, "_unexpected_result"}, 32'd1, 32'd0);
          end else begin
            chk(rtag, 32'(got), 32'(q.pop_front()));
          end
          res++;
        end
        step();
        cyc++;
      end
      chk({rtag, "_result_count"}, 32'(res), 32'(NOPS));
      chk({rtag, "_accept_count"}, 32'(acc), 32'(res));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
